// File: rtl/hamming_pkg.sv
// Shared SECDED definitions: parity-width sizing, codeword index helpers
// and the decode classification type.
package hamming_pkg;

  typedef enum logic [1:0] {
    CLEAN   = 2'd0,
    SINGLE  = 2'd1,
    DOUBLE  = 2'd2,
    INVALID = 2'd3
  } cls_e;

  function automatic int calc_par_w(input int data_w);
    int p;
    p = 0;
    for (int k = 1; k < 8; k++) begin
      if ((p == 0) && ((1 << k) >= (data_w + k + 1))) begin
        p = k;
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  function automatic logic is_pow2(input int idx);
    return (idx > 0) && ((idx & (idx - 1)) == 0);
  endfunction

  // Data bits fill the non-power-of-two indices upward from 3.
  function automatic int data_pos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 3; i < 128; i++) begin
      if (!is_pow2(i)) begin
        if ((cnt == j) && (pos == 0)) begin
          pos = i;
        end else begin
          pos = pos;
        end
        cnt = cnt + 1;
      end else begin
        cnt = cnt;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational Hamming syndrome and overall-parity generator for one
// extended-Hamming codeword.
module hamming_syndrome_calc
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CW_W   = DATA_W + PAR_W + 1
) (
  input  logic [CW_W-1:0]  cw,
  output logic [PAR_W-1:0] syn,
  output logic             glob
);

  // Syndrome is the XOR of the indices of every set bit above the overall parity bit.
  always_comb begin
    syn = '0;
    for (int i = 1; i < CW_W; i++) begin
      syn = syn ^ (cw[i] ? PAR_W'(i) : {PAR_W{1'b0}});
    end
  end

  assign glob = ^cw;

endmodule

// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage pipelined SECDED decoder with a valid/ready stream, optional
// detect-only mode and saturating error counters.
module hamming_secded_decoder_pipe
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CW_W   = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_err_corr,
  output logic              out_err_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam int N = CW_W - 1;

  logic              adv;
  logic [PAR_W-1:0]  in_syn;
  logic              in_glob;
  logic [DATA_W-1:0] in_data;
  cls_e              cls;
  logic              do_fix;
  logic [DATA_W-1:0] fix_data;
  logic              out_hs;

  logic              s1_valid_d, s1_valid_q;
  logic [DATA_W-1:0] s1_data_d,  s1_data_q;
  logic [PAR_W-1:0]  s1_syn_d,   s1_syn_q;
  logic              s1_glob_d,  s1_glob_q;
  logic              s1_cen_d,   s1_cen_q;

  logic              out_valid_d,  out_valid_q;
  logic [DATA_W-1:0] out_data_d,   out_data_q;
  logic [PAR_W-1:0]  out_syn_d,    out_syn_q;
  logic              out_corr_d,   out_corr_q;
  logic              out_uncorr_d, out_uncorr_q;
  logic [CNT_W-1:0]  corr_cnt_d,   corr_cnt_q;
  logic [CNT_W-1:0]  uncorr_cnt_d, uncorr_cnt_q;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  hamming_syndrome_calc #(.DATA_W(DATA_W)) u_syndrome (
    .cw   (in_cw),
    .syn  (in_syn),
    .glob (in_glob)
  );

  // Only the payload bits travel down the pipe; parity bits live on in the syndrome.
  for (genvar j = 0; j < DATA_W; j++) begin : g_data
    localparam int POS = data_pos(j);
    assign in_data[j]  = in_cw[POS];
    assign fix_data[j] = s1_data_q[j] ^ (do_fix && (s1_syn_q == PAR_W'(POS)));
  end

  // Stage 1 capture, stalled as a whole when the output cannot drain.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_syn_d   = s1_syn_q;
    s1_glob_d  = s1_glob_q;
    s1_cen_d   = s1_cen_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_syn_d  = in_syn;
        s1_glob_d = in_glob;
        s1_cen_d  = correct_en;
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Classification of the stage-1 word.
  always_comb begin
    cls = CLEAN;
    if (!s1_glob_q) begin
      if (s1_syn_q == {PAR_W{1'b0}}) begin
        cls = CLEAN;
      end else begin
        cls = DOUBLE;
      end
    end else if (s1_syn_q <= PAR_W'(N)) begin
      cls = SINGLE;
    end else begin
      cls = INVALID;
    end
  end

  assign do_fix = (cls == SINGLE) && s1_cen_q;

  // Stage 2 output register.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_syn_d    = out_syn_q;
    out_corr_d   = out_corr_q;
    out_uncorr_d = out_uncorr_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = fix_data;
        out_syn_d  = s1_syn_q;
        case (cls)
          CLEAN:   begin out_corr_d = 1'b0; out_uncorr_d = 1'b0; end
          SINGLE:  begin out_corr_d = 1'b1; out_uncorr_d = 1'b0; end
          DOUBLE:  begin out_corr_d = 1'b0; out_uncorr_d = 1'b1; end
          INVALID: begin out_corr_d = 1'b0; out_uncorr_d = 1'b1; end
          default: begin out_corr_d = 1'b0; out_uncorr_d = 1'b1; end
        endcase
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  assign out_hs = out_valid_q && out_ready;

  // Saturating event counters; a clear overrides a coincident event.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else begin
      if (out_hs && out_corr_q && (corr_cnt_q != {CNT_W{1'b1}})) begin
        corr_cnt_d = corr_cnt_q + CNT_W'(1'b1);
      end else begin
        corr_cnt_d = corr_cnt_q;
      end
      if (out_hs && out_uncorr_q && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1'b1);
      end else begin
        uncorr_cnt_d = uncorr_cnt_q;
      end
    end
  end

  // All state flops; reset drops any in-flight words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_syn_q     <= '0;
      s1_glob_q    <= 1'b0;
      s1_cen_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_syn_q     <= s1_syn_d;
      s1_glob_q    <= s1_glob_d;
      s1_cen_q     <= s1_cen_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_syn_q    <= out_syn_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_syndrome   = out_syn_q;
  assign out_err_corr   = out_corr_q;
  assign out_err_uncorr = out_uncorr_q;
  assign corr_cnt       = corr_cnt_q;
  assign uncorr_cnt     = uncorr_cnt_q;

endmodule
